// File: rtl/serial_approx_adder.sv
// serial_approx_adder: multi-cycle WIDTH-bit approximate adder that walks
// one 4-bit slice per clock through a single four_bit_CLA.
//
// Optional build macro: SERIAL_APPROX_ERR_DETECT_EN (adds ERR output).
//
// Parameters:
//   WIDTH         operand width, multiple of 4, >= 4
//   APPROX_SLICES number of low 4-bit slices using OR approximation
//
// Ports:
//   CLK        clock, rising edge
//   RST_N      asynchronous active-low reset
//   IN_VALID   operands A/B/C0 valid
//   IN_READY   block can accept operands (IDLE)
//   A, B       WIDTH-bit operands
//   C0         carry-in (ignored when APPROX_SLICES > 0)
//   OUT_VALID  SUM valid (DONE)
//   OUT_READY  downstream accepts SUM
//   SUM        WIDTH+1-bit result, MSB is final carry-out
//   ERR        (macro only) SUM differs from exact A+B+C0 while in DONE

module four_bit_CLA (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C0,
    output logic [4:0] SUM
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = A & B;
    assign p = A ^ B;

    // Flattened lookahead carries.
    assign c[0] = C0;
    assign c[1] = g[0] | (p[0] & C0);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & C0);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & C0);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & C0);

    assign SUM = {c[4], p ^ c[3:0]};
endmodule

module serial_approx_adder #(
    parameter int WIDTH         = 16,
    parameter int APPROX_SLICES = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C0,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
`ifdef SERIAL_APPROX_ERR_DETECT_EN
    output logic [WIDTH:0]   SUM,
    output logic             ERR
`else
    output logic [WIDTH:0]   SUM
`endif
);
    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] LAST = KW'(N - 1);

    // Bit i set when slice i uses the OR approximation.
    function automatic logic [N-1:0] apx_mask_f();
        logic [N-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) begin
            m[i] = (i < APPROX_SLICES);
        end
        return m;
    endfunction

    localparam logic [N-1:0] APX_MASK = apx_mask_f();

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH:0]   sum_q, sum_d;
    logic             carry_q, carry_d;

    logic [KW+1:0]    base;
    logic [3:0]       a_sl;
    logic [3:0]       b_sl;
    logic [4:0]       cla_sum;
    logic             apx;
    logic             cap_carry;

    // Carry seeded at capture: C0 when fully exact, otherwise the
    // generate term of the top approximated bit.
    generate
        if (APPROX_SLICES == 0) begin : g_exact_cin
            assign cap_carry = C0;
        end else begin : g_apx_cin
            logic unused_c0;
            assign unused_c0 = C0;
            assign cap_carry = A[4*APPROX_SLICES-1]
                             & B[4*APPROX_SLICES-1];
        end
    endgenerate

    assign base = {k_q, 2'b00};
    assign a_sl = a_q[base +: 4];
    assign b_sl = b_q[base +: 4];
    assign apx  = APX_MASK[k_q];

    four_bit_CLA u_cla (
        .A   (a_sl),
        .B   (b_sl),
        .C0  (carry_q),
        .SUM (cla_sum)
    );

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
        unique case (state_q)
            IDLE: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    a_d     = A;
                    b_d     = B;
                    k_d     = '0;
                    carry_d = cap_carry;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (apx) begin
                    sum_d[base +: 4] = a_sl | b_sl;
                end else begin
                    sum_d[base +: 4] = cla_sum[3:0];
                    carry_d          = cla_sum[4];
                end
                if (k_q == LAST) begin
                    // A fully approximated top slice yields no carry-out.
                    sum_d[WIDTH] = apx ? 1'b0 : cla_sum[4];
                    state_d      = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                OUT_VALID = 1'b1;
                if (OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign SUM = sum_q;

`ifdef SERIAL_APPROX_ERR_DETECT_EN
    logic           c0_q, c0_d;
    logic [WIDTH:0] exact;

    assign c0_d = (state_q == IDLE && IN_VALID) ? C0 : c0_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            c0_q <= 1'b0;
        end else begin
            c0_q <= c0_d;
        end
    end

    assign exact = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, c0_q};
    assign ERR   = (state_q == DONE) && (sum_q != exact);
`endif

endmodule

// File: doc/serial_approx_adder.md
Name: serial_approx_adder

Overview:
- Multi-cycle wide approximate adder built on one 4-bit carry-lookahead slice (four_bit_CLA: A[3:0], B[3:0], C0 -> SUM[4:0]).
- Accepts WIDTH-bit operands over a valid/ready handshake and processes one 4-bit slice per clock.
- The lowest APPROX_SLICES slices use the low-power OR approximation; the remaining slices are exact CLA additions.
- Sits downstream of the 4-bit CLA and consumes its SUM. Feeds the approximate multiplier's partial-product accumulation.

Parameters:
- WIDTH, 16, operand width; must be a multiple of 4, minimum 4.
- APPROX_SLICES, 1, number of low 4-bit slices approximated; range 0..WIDTH/4.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- IN_VALID  input  1  operands A, B, C0 are valid.
- IN_READY  output  1  block can accept operands.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- C0  input  1  carry-in.
- OUT_VALID  output  1  SUM is valid.
- OUT_READY  input  1  downstream accepts SUM.
- SUM  output  WIDTH+1  result; MSB is the final carry-out.

Behaviour:
- One clock domain. Reset is asynchronous and active-low: RST_N low immediately forces state IDLE, OUT_VALID=0, SUM=0, slice index=0, carry register=0, and operand registers=0. IN_READY reads 1 while in reset.
- FSM states:
  - IDLE: IN_READY=1. IN_VALID=1 at an edge captures A, B, C0 into registers, sets slice index k=0, and moves to RUN.
  - RUN: IN_READY=0. Each cycle processes slice k (bits 4k+3..4k). When k = N-1 (N = WIDTH/4), go to DONE; otherwise k increments.
  - DONE: OUT_VALID=1; SUM and OUT_VALID held stable. OUT_READY=1 at an edge returns to IDLE and OUT_VALID falls.
- Slice arithmetic:
  - Approximate slice (k < APPROX_SLICES): SUM bits = A_slice | B_slice (bitwise OR).
  - C0 is ignored whenever APPROX_SLICES > 0.
  - Carry into the first exact slice = A[4*APPROX_SLICES-1] & B[4*APPROX_SLICES-1].
  - Approximate slices otherwise produce no carry.
  - Exact slice: instantiated four_bit_CLA with C0 = carry register. SUM[3:0] is written to the result slice; SUM[4] is written to the carry register.
  - When APPROX_SLICES=0, the carry register is initialised from C0 at capture.
  - SUM[WIDTH] = carry out of slice N-1. When APPROX_SLICES=N, SUM[WIDTH]=0.
- Latency: with capture at edge t0, OUT_VALID is high after edge tN (N cycles).
- Throughput: one operation per N+2 cycles when OUT_READY is held high. IN_READY returns the cycle after the output handshake.
- IN_VALID outside IDLE is ignored. Operands are not re-sampled.
- OUT_READY outside DONE has no effect.
- A reset asserted mid-RUN or in DONE aborts the operation; no partial result is emitted.
- SUM holds its last value in IDLE. It is only meaningful while OUT_VALID=1.

Optional Feature:
- Macro: SERIAL_APPROX_ERR_DETECT_EN.
- When defined:
  - Adds output port ERR (1 bit).
  - In DONE, ERR=1 iff SUM != exact A+B+C0, computed combinationally from the captured operands.
  - ERR resets to 0 and is 0 outside DONE.
- When undefined: port ERR and the exact-sum logic are absent. Behaviour is otherwise identical.

Test Plan:
- WIDTH=16, APPROX_SLICES=1; A=16'h000A, B=16'h000B, C0=0. Required: OUT_VALID 4 cycles after accept, SUM=17'h0001B, ERR=1 (exact 17'h00015).
- Same configuration; A=16'hFFF0, B=16'h0010, C0=1. Required: SUM=17'h10000 (C0 ignored), ERR=1.
- APPROX_SLICES=0; A=16'hFFFF, B=16'h0001, C0=1. Required: SUM=17'h10001, ERR=0. Also sweep 1000 random vectors: SUM and ERR match the reference model.
- Backpressure: hold OUT_READY=0 for 5 cycles in DONE while toggling IN_VALID and A/B. Required: SUM and OUT_VALID stable, IN_READY=0, no new capture. Release OUT_READY: IDLE next cycle with IN_READY=1.
- Assert RST_N low asynchronously mid-edge during RUN slice k=2. Required: OUT_VALID=0, SUM=0, IN_READY=1 immediately. After release, a new operation (A=16'h1234, B=16'h1111, C0=0, APPROX_SLICES=1) gives SUM=17'h02345.
- Back-to-back with IN_VALID and OUT_READY tied high: accepts occur every 6 cycles (N=4) and each result matches its operands in order.
